// File: rtl/audio_dac_serializer_if.sv
// Sample handshake between the mixer output and the DAC serializer.
// The master drives the sample and valid; the slave answers with ready.
interface audio_dac_serializer_if #(
  parameter int SAMPLE_W = 32
);
  logic [SAMPLE_W-1:0] sample_in;
  logic                sample_valid;
  logic                sample_ready;

  modport master (output sample_in, output sample_valid, input sample_ready);
  modport slave  (input sample_in, input sample_valid, output sample_ready);
endinterface

// File: rtl/audio_dac_serializer.sv
// Buffers mono mixer samples in a small FIFO and streams each one to the codec
// as a left-justified stereo frame (same sample in both slots), MSB first.
module audio_dac_serializer #(
  parameter int CLK_DIV    = 4,
  parameter int SAMPLE_W   = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          resetn,
  audio_dac_serializer_if.slave         smp,
  output logic                          bclk,
  output logic                          lrclk,
  output logic                          dacdat,
  output logic                          underrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int LVL_W  = PTR_W + 1;
  localparam int DIV_W  = $clog2(CLK_DIV);
  localparam int CNT_W  = $clog2(2 * SAMPLE_W);
  localparam int SLOT_W = CNT_W - 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  if (CLK_DIV < 2) begin : g_bad_clk_div
    $error("audio_dac_serializer: CLK_DIV must be at least 2");
  end
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("audio_dac_serializer: FIFO_DEPTH must be a power of 2, at least 2");
  end

  // ---------------------------------------------------------------------------
  // Sample FIFO
  // ---------------------------------------------------------------------------
  logic [SAMPLE_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [LVL_W-1:0]    level;
  logic                push;
  logic                pop;
  logic                fifo_empty;
  logic [SAMPLE_W-1:0] head;

  // Ready depends on the stored level only, so a pop in the same cycle never
  // frees a slot early and the mixer sees no combinational path through us.
  assign smp.sample_ready = (level != LVL_W'(FIFO_DEPTH));
  assign push             = smp.sample_valid && smp.sample_ready;
  assign fifo_empty       = (level == '0);
  assign head             = mem[rd_ptr];
  assign fifo_level       = level;

  // NOTE: storage has no reset; discarding contents only needs the pointers
  // and level cleared, and leaving the array unreset keeps it a plain RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= smp.sample_in;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      unique case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Serializer FSM
  // ---------------------------------------------------------------------------
  logic [0:0]          state;
  logic [DIV_W-1:0]    div;
  logic [CNT_W-1:0]    bit_cnt;
  logic [SAMPLE_W-1:0] hold;

  logic                div_wrap;
  logic                bclk_fall;
  logic [CNT_W-1:0]    cnt_next;
  logic                frame_start;
  logic [SAMPLE_W-1:0] hold_shifted;

  // NOTE: every signal assigned here gets a default first, so no path through
  // the block can leave a value held and infer a latch.
  always_comb begin
    div_wrap     = 1'b0;
    bclk_fall    = 1'b0;
    cnt_next     = bit_cnt + CNT_W'(1);
    frame_start  = 1'b0;
    hold_shifted = hold << cnt_next[SLOT_W-1:0];
    pop          = 1'b0;
    if (state == ST_RUN) begin
      div_wrap    = (div == DIV_W'(CLK_DIV - 1));
      bclk_fall   = div_wrap && bclk;
      frame_start = bclk_fall && (cnt_next == '0);
      pop         = frame_start && !fifo_empty;
    end else begin
      pop = !fifo_empty;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= ST_IDLE;
      div      <= '0;
      bit_cnt  <= '0;
      hold     <= '0;
      bclk     <= 1'b0;
      lrclk    <= 1'b0;
      dacdat   <= 1'b0;
      underrun <= 1'b0;
    end else begin
      // NOTE: underrun defaults low every cycle so a frame-start hit can only
      // ever raise it for a single clock.
      underrun <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            state   <= ST_RUN;
            hold    <= head;
            dacdat  <= head[SAMPLE_W-1];
            lrclk   <= 1'b1;
            bit_cnt <= '0;
            div     <= '0;
            bclk    <= 1'b0;
          end
        end
        ST_RUN: begin
          if (div_wrap) begin
            div  <= '0;
            bclk <= ~bclk;
            if (bclk_fall) begin
              bit_cnt <= cnt_next;
              // Upper half of the frame is the right slot.
              lrclk   <= ~cnt_next[CNT_W-1];
              if (frame_start) begin
                if (!fifo_empty) begin
                  hold   <= head;
                  dacdat <= head[SAMPLE_W-1];
                end else begin
                  hold     <= '0;
                  dacdat   <= 1'b0;
                  underrun <= 1'b1;
                end
              end else begin
                dacdat <= hold_shifted[SAMPLE_W-1];
              end
            end
          end else begin
            div <= div + DIV_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_audio_dac_serializer.sv
// Randomized bench for audio_dac_serializer: a sample-queue reference model
// predicts FIFO level, frame contents, underrun pulses and bit-clock timing.
module tb_audio_dac_serializer;

  localparam int CLK_DIV    = 4;
  localparam int SAMPLE_W   = 32;
  localparam int FIFO_DEPTH = 4;
  localparam int FRAME_CLKS = 4 * SAMPLE_W * CLK_DIV;

  logic       clk    = 1'b0;
  logic       resetn = 1'b1;
  logic       bclk;
  logic       lrclk;
  logic       dacdat;
  logic       underrun;
  logic [2:0] fifo_level;

  always #5 clk = ~clk;

  audio_dac_serializer_if #(.SAMPLE_W(SAMPLE_W)) smp ();

  audio_dac_serializer #(
    .CLK_DIV   (CLK_DIV),
    .SAMPLE_W  (SAMPLE_W),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .smp       (smp.slave),
    .bclk      (bclk),
    .lrclk     (lrclk),
    .dacdat    (dacdat),
    .underrun  (underrun),
    .fifo_level(fifo_level)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: queue of samples the DUT holds but has not yet framed.
  // ---------------------------------------------------------------------------
  logic [31:0] q[$];
  logic        pend_push = 1'b0;
  logic [31:0] pend_data = '0;
  logic        running   = 1'b0;
  int          k         = 0;
  logic [31:0] cur       = '0;
  logic        prev_bclk = 1'b0, prev_lrclk = 1'b0, prev_dacdat = 1'b0;
  longint      cyc = 0, frame_cyc = 0, toggle_cyc = 0;
  int          frames_started = 0;
  int          underruns_seen = 0;
  logic        ready_low_seen = 1'b0;
  logic        fell, rose, fstart;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!resetn) begin
      check("rst_bclk", bclk, 0);
      check("rst_lrclk", lrclk, 0);
      check("rst_dacdat", dacdat, 0);
      check("rst_underrun", underrun, 0);
      check("rst_level", fifo_level, 0);
      check("rst_ready", smp.sample_ready, 1);
      q.delete();
      pend_push   = 1'b0;
      running     = 1'b0;
      k           = 0;
      cur         = '0;
      prev_bclk   = 1'b0;
      prev_lrclk  = 1'b0;
      prev_dacdat = 1'b0;
    end else begin
      fell   = prev_bclk && !bclk;
      rose   = !prev_bclk && bclk;
      fstart = lrclk && !prev_lrclk;

      if ((lrclk != prev_lrclk) || (dacdat != prev_dacdat))
        check("edge_align", fell || (fstart && !running), 1);

      if (fstart) begin
        if (running) check("frame_len", cyc - frame_cyc, FRAME_CLKS);
        else toggle_cyc = cyc;
        frame_cyc = cyc;
        frames_started++;
        check("underrun", underrun, q.size() == 0);
        if (q.size() == 0) begin
          cur = '0;
          underruns_seen++;
        end else begin
          cur = q.pop_front();
        end
        k = 0;
      end else begin
        check("underrun_quiet", underrun, 0);
        if (!running) check("idle_out", {bclk, lrclk, dacdat}, 0);
      end

      if (running && (bclk != prev_bclk)) begin
        check("bclk_half", cyc - toggle_cyc, CLK_DIV);
        toggle_cyc = cyc;
      end

      if (running && rose) begin
        check("lr_slot", lrclk, k < SAMPLE_W);
        check("data_bit", dacdat, cur[SAMPLE_W-1-(k % SAMPLE_W)]);
        k++;
      end

      if (fstart) running = 1'b1;
      if (pend_push) q.push_back(pend_data);
      check("level", fifo_level, q.size());
      check("ready", smp.sample_ready, q.size() != FIFO_DEPTH);
      if (!smp.sample_ready) ready_low_seen = 1'b1;

      pend_push   = smp.sample_valid && smp.sample_ready;
      pend_data   = smp.sample_in;
      prev_bclk   = bclk;
      prev_lrclk  = lrclk;
      prev_dacdat = dacdat;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (inputs change at posedge + 1)
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_sample(input logic [31:0] data);
    for (int t = 0; t < 4 * FRAME_CLKS; t++) begin
      if (smp.sample_ready) begin
        smp.sample_valid = 1'b1;
        smp.sample_in    = data;
        step();
        smp.sample_valid = 1'b0;
        return;
      end
      step();
    end
    check("push_timeout", 0, 1);
  endtask

  task automatic wait_frames(input int n);
    int target;
    target = frames_started + n;
    wait (frames_started >= target);
    step();
  endtask

  task automatic grab_bits(input int n, output logic [63:0] bits);
    bits = '0;
    for (int i = 0; i < n; i++) begin
      @(posedge bclk);
      #1;
      bits = {bits[62:0], dacdat};
    end
  endtask

  logic [63:0] bits;
  int          u0;
  longint      t1, t2;

  initial begin
    smp.sample_valid = 1'b0;
    smp.sample_in    = '0;

    // Reset with random inputs.
    #1 resetn = 1'b0;
    for (int i = 0; i < 6; i++) begin
      smp.sample_valid = 1'($urandom);
      smp.sample_in    = $urandom;
      step();
    end
    smp.sample_valid = 1'b0;
    resetn = 1'b1;
    repeat (300) step();
    check("idle_hold", {bclk, lrclk, dacdat, underrun}, 0);
    check("idle_level", fifo_level, 0);

    // Single sample: MSB-first bits, repeated right slot, then an underrun frame.
    u0 = underruns_seen;
    push_sample(32'hA500_0000);
    wait_frames(1);
    check("start_lrclk", lrclk, 1);
    check("start_dacdat", dacdat, 1);
    grab_bits(8, bits);
    check("first_byte", bits[7:0], 8'hA5);
    grab_bits(24, bits);
    check("left_tail", bits[23:0], 24'h0);
    check("left_slot_lr", lrclk, 1);
    @(posedge bclk);
    #1;
    check("right_slot_lr", lrclk, 0);
    bits = {63'h0, dacdat};
    for (int i = 1; i < 32; i++) begin
      @(posedge bclk);
      #1;
      bits = {bits[62:0], dacdat};
    end
    check("right_slot_word", bits[31:0], 32'hA500_0000);
    wait_frames(1);
    check("underrun_count", underruns_seen - u0, 1);

    // Back-pressure: continuous valid with values 1..6.
    ready_low_seen   = 1'b0;
    smp.sample_valid = 1'b1;
    for (int v = 1; v <= 6; v++) begin
      logic r;
      smp.sample_in = 32'(v);
      do begin
        r = smp.sample_ready;
        step();
      end while (!r);
    end
    smp.sample_valid = 1'b0;
    check("ready_dropped", ready_low_seen, 1);
    u0 = underruns_seen;
    wait (q.size() == 0);
    step();
    check("no_underrun_stream", underruns_seen - u0, 0);
    wait_frames(1);

    // Push coinciding exactly with a frame-start pop at level 1.
    wait_frames(1);
    push_sample(32'h1234_5678);
    check("simul_pre_level", fifo_level, 1);
    while (cyc != frame_cyc + FRAME_CLKS - 1) step();
    smp.sample_valid = 1'b1;
    smp.sample_in    = 32'hCAFE_F00D;
    step();
    smp.sample_valid = 1'b0;
    check("simul_level", fifo_level, 1);
    wait_frames(2);

    // Randomized traffic with gaps long enough to cause underruns.
    for (int i = 0; i < 40; i++) begin
      int burst;
      repeat ($urandom_range(0, 700)) step();
      burst = $urandom_range(1, 3);
      for (int b = 0; b < burst; b++) push_sample($urandom);
    end
    @(posedge bclk);
    #1 t1 = cyc;
    @(posedge bclk);
    #1 t2 = cyc;
    check("bclk_period", t2 - t1, 2 * CLK_DIV);
    wait_frames(2);

    // Reset in the middle of a frame, then a fresh sample.
    push_sample(32'hDEAD_BEEF);
    wait_frames(1);
    wait (k == 17);
    step();
    #2 resetn = 1'b0;
    #1;
    check("async_rst_out", {bclk, lrclk, dacdat, underrun}, 0);
    check("async_rst_level", fifo_level, 0);
    check("async_rst_ready", smp.sample_ready, 1);
    repeat (3) step();
    resetn = 1'b1;
    step();
    u0 = underruns_seen;
    push_sample(32'h8000_0001);
    wait_frames(1);
    check("restart_lrclk", lrclk, 1);
    check("restart_msb", dacdat, 1);
    grab_bits(32, bits);
    check("restart_word", bits[31:0], 32'h8000_0001);
    wait_frames(1);
    check("restart_underrun", underruns_seen - u0, 1);
    repeat (20) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
